// File: rtl/sim_mon_pkg.sv
// Shared types and helpers for the simulation result monitor.
package sim_mon_pkg;

  typedef enum logic [1:0] {IDLE, RUN, REPORT, DONE} state_t;

  localparam int RES_WORDS = 5;
  localparam logic [31:0] SIG_POLY_DEFAULT = 32'h04C1_1DB7;

  // XOR the eight 32-bit chunks of a zero-padded 256-bit sample together.
  function automatic logic [31:0] fold(input logic [255:0] y);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      acc ^= y[i*32 +: 32];
    end
    return acc;
  endfunction

endpackage

// File: rtl/lsb_index.sv
// Combinational encoder for the index of the lowest set bit of a vector.
module lsb_index #(
  parameter int W = 233
) (
  input  logic [W-1:0] vec,
  output logic [7:0]   idx,
  output logic         any
);

  // Scan from the top down so the lowest set bit wins the last assignment.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 8'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sim_result_monitor.sv
// Compares netlist vs golden output streams, signs both with MISRs and
// streams a five-word pass/fail record over a valid/ready port.
module sim_result_monitor
  import sim_mon_pkg::*;
#(
  parameter int          WIDTH       = 233,
  parameter int          NUM_SAMPLES = 22,
  parameter logic [31:0] SIG_INIT    = 32'h0000_0000,
  parameter logic [31:0] SIG_POLY    = SIG_POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] y_ref,
  input  logic [WIDTH-1:0] y_dut,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_last,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam logic [15:0] NUM16     = 16'(NUM_SAMPLES);
  localparam logic [15:0] LAST_IDX  = 16'(NUM_SAMPLES - 1);
  localparam logic [2:0]  LAST_WORD = 3'(RES_WORDS - 1);

  state_t      state;
  logic [15:0] sample_idx;
  logic [15:0] mismatch_cnt;
  logic        first_valid;
  logic [15:0] first_cycle;
  logic [7:0]  first_bit;
  logic [31:0] sig_ref;
  logic [31:0] sig_dut;
  logic [2:0]  word_ptr;

  logic [WIDTH-1:0] diff;
  logic [7:0]       diff_lsb;
  logic             diff_any;
  logic [255:0]     ref_pad;
  logic [255:0]     dut_pad;
  logic [31:0]      sig_ref_next;
  logic [31:0]      sig_dut_next;
  logic [31:0]      res_word;

  assign diff = y_ref ^ y_dut;

  lsb_index #(.W(WIDTH)) u_lsb_index (
    .vec (diff),
    .idx (diff_lsb),
    .any (diff_any)
  );

  always_comb begin
    ref_pad = '0;
    dut_pad = '0;
    ref_pad[WIDTH-1:0] = y_ref;
    dut_pad[WIDTH-1:0] = y_dut;
  end

  assign sig_ref_next = {sig_ref[30:0], 1'b0} ^ (sig_ref[31] ? SIG_POLY : 32'h0) ^ fold(ref_pad);
  assign sig_dut_next = {sig_dut[30:0], 1'b0} ^ (sig_dut[31] ? SIG_POLY : 32'h0) ^ fold(dut_pad);

  always_comb begin
    res_word = '0;
    case (word_ptr)
      3'd0:    res_word = {16'h0, NUM16};
      3'd1:    res_word = {16'h0, mismatch_cnt};
      3'd2:    res_word = first_valid ? {first_cycle, 8'h00, first_bit} : 32'hFFFF_FFFF;
      3'd3:    res_word = sig_ref;
      3'd4:    res_word = sig_dut;
      default: res_word = '0;
    endcase
  end

  // Gated by valid so the port reads all-zero outside REPORT.
  assign res_data = res_valid ? res_word : 32'h0;
  assign res_last = res_valid && (word_ptr == LAST_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sample_idx   <= '0;
      mismatch_cnt <= '0;
      first_valid  <= 1'b0;
      first_cycle  <= '0;
      first_bit    <= '0;
      sig_ref      <= SIG_INIT;
      sig_dut      <= SIG_INIT;
      word_ptr     <= '0;
      res_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RUN;
            sample_idx   <= '0;
            mismatch_cnt <= '0;
            first_valid  <= 1'b0;
            sig_ref      <= SIG_INIT;
            sig_dut      <= SIG_INIT;
            word_ptr     <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
          end
        end

        RUN: begin
          if (sample_en) begin
            sig_ref    <= sig_ref_next;
            sig_dut    <= sig_dut_next;
            sample_idx <= sample_idx + 16'd1;
            if (diff_any) begin
              if (mismatch_cnt != 16'hFFFF) begin
                mismatch_cnt <= mismatch_cnt + 16'd1;
              end
              if (!first_valid) begin
                first_valid <= 1'b1;
                first_cycle <= sample_idx;
                first_bit   <= diff_lsb;
              end
            end
            if (sample_idx == LAST_IDX) begin
              state     <= REPORT;
              res_valid <= 1'b1;
              word_ptr  <= '0;
            end
          end
        end

        REPORT: begin
          if (res_ready) begin
            if (word_ptr == LAST_WORD) begin
              state     <= DONE;
              res_valid <= 1'b0;
              word_ptr  <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (mismatch_cnt == 16'h0) && (sig_ref == sig_dut);
            end else begin
              word_ptr <= word_ptr + 3'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_result_monitor.sv
// Directed self-checking bench for sim_result_monitor (default and 4-sample builds).
module tb_sim_result_monitor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, sample_en, res_ready;
  logic [232:0] y_ref, y_dut;
  logic         res_valid, res_last, busy, done, pass;
  logic [31:0]  res_data;

  logic         start4, en4, ready4;
  logic [232:0] y4;
  logic         res_valid4, res_last4, busy4, done4, pass4;
  logic [31:0]  res_data4;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rec [5];
  logic [31:0] rec4 [5];

  always #5 clk = ~clk;

  sim_result_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_en(sample_en),
    .y_ref(y_ref), .y_dut(y_dut), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_last(res_last), .busy(busy), .done(done), .pass(pass)
  );

  sim_result_monitor #(.NUM_SAMPLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sample_en(en4),
    .y_ref(y4), .y_dut(y4), .res_valid(res_valid4), .res_ready(ready4),
    .res_data(res_data4), .res_last(res_last4), .busy(busy4), .done(done4), .pass(pass4)
  );

  function automatic logic [31:0] tb_fold(input logic [232:0] y);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 233; i++) r[i % 32] = r[i % 32] ^ y[i];
    return r;
  endfunction

  function automatic logic [31:0] tb_misr(input logic [31:0] s, input logic [232:0] y);
    logic [31:0] fb;
    fb = s[31] ? 32'h04C1_1DB7 : 32'h0;
    return (s << 1) ^ fb ^ tb_fold(y);
  endfunction

  function automatic logic [232:0] rand_y();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[232:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [232:0] r, input logic [232:0] d);
    sample_en = en;
    y_ref = r;
    y_dut = d;
    @(posedge clk); #1;
    sample_en = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drains one record; bp selects the 1,0,0 ready pattern instead of ready held high.
  task automatic collectRecord(input bit bp);
    int k, cyc;
    logic held_valid;
    logic [31:0] held;
    k = 0; cyc = 0; held_valid = 1'b0; held = '0;
    while (k < 5 && cyc < 100) begin
      res_ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (held_valid) checkOutput("hold_data", res_data, held);
      if (res_valid && res_ready) begin
        rec[k] = res_data;
        checkOutput("res_last", 32'(res_last), 32'(k == 4));
        k++;
        held_valid = 1'b0;
      end else begin
        held_valid = res_valid;
        held = res_data;
      end
      @(posedge clk); #1;
      cyc++;
    end
    res_ready = 1'b0;
    checkOutput("transfers", 32'(k), 32'd5);
    if (!bp) checkOutput("burst_cycles", 32'(cyc), 32'd5);
    checkOutput("done_after", 32'(done), 32'd1);
    checkOutput("valid_after", 32'(res_valid), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [232:0] r, d;
    logic [31:0]  er, ed;
    int k4, cyc4;

    rst_n = 1'b0; start = 1'b0; sample_en = 1'b0; res_ready = 1'b0;
    y_ref = '0; y_dut = '0;
    start4 = 1'b0; en4 = 1'b0; ready4 = 1'b0; y4 = '0;
    repeat (2) @(posedge clk); #1;
    checkOutput("rst_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_data", res_data, 32'd0);
    checkOutput("rst_last", 32'(res_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_pass", 32'(pass), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] identical streams");
    pulseStart();
    checkOutput("start_busy", 32'(busy), 32'd1);
    er = 32'h0;
    for (int i = 0; i < 22; i++) begin
      r = rand_y();
      er = tb_misr(er, r);
      applyStimulus(1'b1, r, r);
    end
    checkOutput("valid_rise", 32'(res_valid), 32'd1);
    collectRecord(1'b0);
    checkOutput("id_w0", rec[0], 32'd22);
    checkOutput("id_w1", rec[1], 32'd0);
    checkOutput("id_w2", rec[2], 32'hFFFF_FFFF);
    checkOutput("id_w3", rec[3], er);
    checkOutput("id_w4", rec[4], er);
    checkOutput("id_pass", 32'(pass), 32'd1);

    $display("[TB] single-bit divergence with backpressure");
    pulseStart();
    checkOutput("pass_cleared", 32'(pass), 32'd0);
    checkOutput("done_cleared", 32'(done), 32'd0);
    er = 32'h0; ed = 32'h0;
    for (int i = 0; i < 22; i++) begin
      r = rand_y();
      d = r;
      if (i == 5) d[100] = ~d[100];
      er = tb_misr(er, r);
      ed = tb_misr(ed, d);
      applyStimulus(1'b1, r, d);
    end
    collectRecord(1'b1);
    checkOutput("sb_w0", rec[0], 32'd22);
    checkOutput("sb_w1", rec[1], 32'd1);
    checkOutput("sb_w2", rec[2], 32'h0005_0064);
    checkOutput("sb_w3", rec[3], er);
    checkOutput("sb_w4", rec[4], ed);
    checkOutput("sb_pass", 32'(pass), 32'd0);

    $display("[TB] gaps and ignored start");
    pulseStart();
    er = 32'h0; ed = 32'h0;
    for (int i = 0; i < 22; i++) begin
      if (i == 10) begin
        applyStimulus(1'b0, '0, '1);
        start = 1'b1;
        applyStimulus(1'b0, '1, '0);
        start = 1'b0;
        applyStimulus(1'b0, '0, '1);
        checkOutput("gap_valid", 32'(res_valid), 32'd0);
        checkOutput("gap_busy", 32'(busy), 32'd1);
      end
      r = rand_y();
      d = r;
      if (i == 3) d[0] = ~d[0];
      if (i == 15) d[232] = ~d[232];
      er = tb_misr(er, r);
      ed = tb_misr(ed, d);
      if (i == 21) checkOutput("pre_final_valid", 32'(res_valid), 32'd0);
      applyStimulus(1'b1, r, d);
    end
    checkOutput("gap_final_valid", 32'(res_valid), 32'd1);
    collectRecord(1'b0);
    checkOutput("gap_w0", rec[0], 32'd22);
    checkOutput("gap_w1", rec[1], 32'd2);
    checkOutput("gap_w2", rec[2], 32'h0003_0000);
    checkOutput("gap_w3", rec[3], er);
    checkOutput("gap_w4", rec[4], ed);

    $display("[TB] reset mid-report");
    pulseStart();
    for (int i = 0; i < 22; i++) begin
      r = rand_y();
      d = r;
      if (i == 7) d[40] = ~d[40];
      applyStimulus(1'b1, r, d);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checkOutput("pre_abort_valid", 32'(res_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(res_valid), 32'd0);
    checkOutput("abort_data", res_data, 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    pulseStart();
    for (int i = 0; i < 22; i++) begin
      r = rand_y();
      applyStimulus(1'b1, r, r);
    end
    collectRecord(1'b0);
    checkOutput("fresh_w0", rec[0], 32'd22);
    checkOutput("fresh_w1", rec[1], 32'd0);
    checkOutput("fresh_w2", rec[2], 32'hFFFF_FFFF);
    checkOutput("fresh_pass", 32'(pass), 32'd1);

    $display("[TB] signature arithmetic, 4 samples");
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en4 = 1'b1;
      y4 = (i == 0) ? 233'd1 : 233'd0;
      @(posedge clk); #1;
    end
    en4 = 1'b0;
    ready4 = 1'b1;
    k4 = 0; cyc4 = 0;
    while (k4 < 5 && cyc4 < 20) begin
      if (res_valid4) begin
        rec4[k4] = res_data4;
        k4++;
      end
      @(posedge clk); #1;
      cyc4++;
    end
    ready4 = 1'b0;
    checkOutput("m4_transfers", 32'(k4), 32'd5);
    checkOutput("m4_w0", rec4[0], 32'd4);
    checkOutput("m4_w3", rec4[3], 32'h0000_0008);
    checkOutput("m4_w4", rec4[4], 32'h0000_0008);
    checkOutput("m4_pass", 32'(pass4), 32'd1);
    checkOutput("m4_done", 32'(done4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sim_result_monitor.md
# sim_result_monitor

Downstream consumer of the fuzz DUT output bus `y`. Each sampled cycle it compares the synthesized netlist's `y` against the golden RTL simulation's `y`. It counts mismatches, locates the first divergence, and folds both streams into 32-bit MISR signatures. At the end of a run it streams a five-word result record over a valid/ready port. This replaces per-cycle `$strobe` text dumps with a compact, synthesizable pass/fail summary.

## Interface
- `WIDTH`, 233: width of `y` (bits 232:0)
- `NUM_SAMPLES`, 22: samples per run (1..65535)
- `SIG_INIT`, 32'h0000_0000: MISR seed
- `SIG_POLY`, 32'h04C1_1DB7: MISR feedback polynomial

Ports:
- `clk`  in  1  sole clock; everything samples on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a run; honoured only in IDLE or DONE
- `sample_en`  in  1  `y_ref`/`y_dut` valid this cycle
- `y_ref`  in  WIDTH  golden output
- `y_dut`  in  WIDTH  netlist output
- `res_valid`  out  1  result word valid
- `res_ready`  in  1  result consumer ready
- `res_data`  out  32  result word
- `res_last`  out  1  marks word 4
- `busy`  out  1  state is RUN or REPORT
- `done`  out  1  state is DONE
- `pass`  out  1  run clean; valid while `done`

## Operation
- States: IDLE → RUN → REPORT → DONE → (start) RUN.
- **Reset:**
  - Forces IDLE.
  - All outputs and counters are 0.
  - Both signatures are `SIG_INIT`.
- **`start` in IDLE or DONE:**
  - Clears `sample_idx`, `mismatch_cnt` and `first_valid`.
  - Loads both signatures with `SIG_INIT`.
  - Enters RUN.
- `start` in RUN or REPORT is ignored.
- **RUN, `sample_en`=1:**
  - `diff = y_ref ^ y_dut`.
  - If `diff` is nonzero, `mismatch_cnt` increments, saturating at 16'hFFFF.
  - If `diff` is nonzero and `first_valid`=0, capture `first_cycle = sample_idx` and `first_bit` = lowest set index of `diff` (8 bits). Then set `first_valid`.
  - Update each signature: `sig' = {sig[30:0],1'b0} ^ (sig[31] ? SIG_POLY : 0) ^ fold(y)`.
  - `fold(y)` zero-pads `y` to 256 bits and XORs its eight 32-bit chunks.
  - `sample_idx` increments (16 bits).
  - On the sample with `sample_idx == NUM_SAMPLES-1`, go to REPORT.
- RUN, `sample_en`=0: no state change.
- **REPORT** emits words 0..4, one per handshake:
  - w0 = `{16'h0, NUM_SAMPLES}`
  - w1 = `{16'h0, mismatch_cnt}`
  - w2 = `first_valid ? {first_cycle, 8'h00, first_bit} : 32'hFFFF_FFFF`
  - w3 = `sig_ref`
  - w4 = `sig_dut`
- After the w4 handshake, go to DONE.
- `pass = (mismatch_cnt == 0) && (sig_ref == sig_dut)`. Registered on entry to DONE; cleared on `start`.

## Timing
- Sample to counter update: latency 1 (registered at the sampling edge).
- `res_valid` rises the cycle after the final sample's edge.
- **Handshake:**
  - A transfer occurs when `res_valid && res_ready` at an edge.
  - `res_data` and `res_last` are stable while `res_valid && !res_ready`.
  - `res_valid` never drops without a transfer.
  - `res_ready` held high gives 5 consecutive cycles.
- `done` rises the cycle after the w4 transfer. `res_valid` is 0 in that cycle.
- `busy` and `done` are never both high.
- Asserting `rst_n` mid-RUN or mid-REPORT aborts immediately. `res_valid` drops asynchronously. No partial record resumes.
- In RUN, `sample_en` may be held high continuously; no bubbles are required.

## Structure
- Package `sim_mon_pkg`:
  - state enum `{IDLE, RUN, REPORT, DONE}`
  - `RES_WORDS = 5`
  - default `SIG_POLY`
  - `fold` function
- Sub-module `lsb_index #(.W(WIDTH))`: combinational lowest-set-bit encoder, output 8 bits, plus an `any` flag. Used for `first_bit`.
- The MISR update is instanced twice, inline. A 3-bit word pointer drives the result mux.

## Test plan
- **Identical streams:**
  - Stimulus: 22 samples, `y_ref = y_dut`, random values.
  - Required: w1 = 0, w2 = FFFF_FFFF, w3 = w4, `pass` = 1.
- **Single-bit divergence:**
  - Stimulus: sample 5 only, `y_dut[100]` flipped.
  - Required: w1 = 1, w2 = 32'h0005_0064, `pass` = 0.
- **Signature arithmetic:**
  - Stimulus: `NUM_SAMPLES` = 4. `y` = 1 then three zeros, both sides.
  - Required: w3 = w4 = 32'h0000_0008.
- **Backpressure:**
  - Stimulus: `res_ready` toggled 1,0,0,1,…
  - Required: each word is stable until taken; exactly 5 transfers; `res_last` only on w4; `done` the cycle after.
- **Gaps and ignored start:**
  - Stimulus: `sample_en` low for 3 cycles mid-run; `start` pulsed in RUN.
  - Required: `sample_idx` unchanged across the gaps; the run is not restarted.
- **Reset mid-REPORT:**
  - Stimulus: `rst_n` low after w1 is taken.
  - Required: `res_valid` = 0 immediately; IDLE state; a new `start` produces a fresh full record from w0.
